// File: rtl/acorn128_stream_loader.sv
// Purpose: packs an 18-word ingress job into ACORN-128 core buses, starts the core, and streams the 256-bit result+tag back as 8 words.
// Latency: last ingress word -> start_out 1 cycle; core_ready_in -> m_valid_out 1 cycle.
// Backpressure: s_ready_out is low outside IDLE/LOAD; egress holds data/last while m_ready_in is low.
//
// Ports: s_* ingress word stream (valid/ready, last, direction with word 0); key/iv/ad/plaintext/ciphertext/
// data_length/start/encrypt_out drive the core; core_* inputs return its results; m_* egress word stream;
// busy/frame_err/timeout_out are status (errors sticky until the next job starts).
// Optional build macro ACORN_LOADER_ZEROIZE_EN clears all data registers on every return to IDLE.
module acorn128_stream_loader #(
  parameter int TIMEOUT_CYC = 8192,
  parameter int WORD_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid_in,
  output logic              s_ready_out,
  input  logic [WORD_W-1:0] s_data_in,
  input  logic              s_last_in,
  input  logic              s_encrypt_in,
  output logic [127:0]      key_out,
  output logic [127:0]      iv_out,
  output logic [127:0]      associated_data_out,
  output logic [127:0]      plaintext_out,
  output logic [127:0]      ciphertext_out,
  output logic [63:0]       data_length_out,
  output logic              start_out,
  output logic              encrypt_out,
  input  logic              core_ready_in,
  input  logic [127:0]      core_ciphertext_in,
  input  logic [127:0]      core_plaintext_in,
  input  logic [127:0]      core_tag_in,
  output logic              m_valid_out,
  input  logic              m_ready_in,
  output logic [WORD_W-1:0] m_data_out,
  output logic              m_last_out,
  output logic              busy_out,
  output logic              frame_err_out,
  output logic              timeout_out
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_s_ready;
  logic [4:0]     r_word_cnt;   // ingress word index in LOAD, egress word index in DRAIN
  logic [TW-1:0]  r_tmo_cnt;
  logic [127:0]   r_key, r_iv, r_ad, r_pay;
  logic [63:0]    r_len;
  logic [255:0]   r_shift;
  logic           r_start, r_encrypt, r_m_valid, r_frame_err, r_timeout;

  logic           w_accept, w_load, w_frame_err, w_go_run, w_capture, w_tmo_hit;
  logic           w_m_fire, w_drain_done;
  logic [4:0]     w_idx;
  logic [TW-1:0]  w_tmo_inc;

  assign w_accept  = s_valid_in && r_s_ready;
  assign w_m_fire  = r_m_valid && m_ready_in;
  assign w_tmo_inc = r_tmo_cnt + TW'(1);
  // Word 0 arrives in IDLE where the counter holds stale drain state.
  assign w_idx     = (r_state == ST_IDLE) ? 5'd0 : r_word_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_frame_err  = 1'b0;
    w_go_run     = 1'b0;
    w_capture    = 1'b0;
    w_tmo_hit    = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (s_last_in) w_frame_err = 1'b1;
          else           w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (s_last_in != (r_word_cnt == 5'd17)) begin
            w_frame_err = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_word_cnt == 5'd17) begin
            w_go_run    = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Ready takes priority over a timeout landing on the same cycle.
        if (core_ready_in) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (w_tmo_inc == TW'(TIMEOUT_CYC)) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        if (w_m_fire && (r_word_cnt == 5'd7)) begin
          w_drain_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_ready   <= 1'b0;
      r_word_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_key       <= '0;
      r_iv        <= '0;
      r_ad        <= '0;
      r_pay       <= '0;
      r_len       <= '0;
      r_shift     <= '0;
      r_start     <= 1'b0;
      r_encrypt   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
      if (r_state == ST_RUN) r_tmo_cnt <= w_tmo_inc;
      if (w_load) begin
        if (r_state == ST_IDLE) begin
          r_encrypt   <= s_encrypt_in;
          r_frame_err <= 1'b0;
          r_timeout   <= 1'b0;
          r_word_cnt  <= 5'd1;
        end else begin
          r_word_cnt  <= r_word_cnt + 5'd1;
        end
        // Fields arrive MSW first, so each one is a left-shifting register.
        if (w_idx < 5'd4)       r_key <= {r_key[95:0], s_data_in};
        else if (w_idx < 5'd8)  r_iv  <= {r_iv[95:0],  s_data_in};
        else if (w_idx < 5'd12) r_ad  <= {r_ad[95:0],  s_data_in};
        else if (w_idx < 5'd16) r_pay <= {r_pay[95:0], s_data_in};
        else                    r_len <= {r_len[31:0], s_data_in};
      end
      if (w_frame_err) r_frame_err <= 1'b1;
      if (w_go_run) begin
        r_start    <= 1'b1;
        r_tmo_cnt  <= '0;
        r_word_cnt <= '0;
      end
      if (w_capture) begin
        r_shift   <= {(r_encrypt ? core_ciphertext_in : core_plaintext_in), core_tag_in};
        r_start   <= 1'b0;
        r_m_valid <= 1'b1;
      end
      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
        r_start   <= 1'b0;
      end
      if (w_m_fire) begin
        r_shift    <= {r_shift[223:0], 32'h0};
        r_word_cnt <= r_word_cnt + 5'd1;
        if (w_drain_done) r_m_valid <= 1'b0;
      end
`ifdef ACORN_LOADER_ZEROIZE_EN
      if (w_frame_err || w_tmo_hit || w_drain_done) begin
        r_key   <= '0;
        r_iv    <= '0;
        r_ad    <= '0;
        r_pay   <= '0;
        r_len   <= '0;
        r_shift <= '0;
      end
`else
      // Data registers keep their contents until the next job overwrites them.
`endif
    end
  end

  assign s_ready_out         = r_s_ready;
  assign key_out             = r_key;
  assign iv_out              = r_iv;
  assign associated_data_out = r_ad;
  assign plaintext_out       = r_encrypt ? r_pay : 128'h0;
  assign ciphertext_out      = r_encrypt ? 128'h0 : r_pay;
  assign data_length_out     = r_len;
  assign start_out           = r_start;
  assign encrypt_out         = r_encrypt;
  assign m_valid_out         = r_m_valid;
  assign m_data_out          = r_shift[255:224];
  assign m_last_out          = r_m_valid && (r_word_cnt == 5'd7);
  assign busy_out            = (r_state != ST_IDLE);
  assign frame_err_out       = r_frame_err;
  assign timeout_out         = r_timeout;

endmodule

// File: doc/acorn128_stream_loader.md
Name: acorn128_stream_loader

Overview:
Upstream/downstream adapter for the ACORN-128 core.
- Ingress: collects a 32-bit word stream (key, IV, associated data, payload, length) into the core's wide input buses.
- Control: raises `start_out` and waits for the core's ready.
- Egress: captures the 128-bit result and tag, then streams them out as 32-bit words.
- Sits between the host/DMA word interface and the core's 128-bit parallel ports.

Parameters:
- TIMEOUT_CYC, 8192, max cycles in RUN waiting for `core_ready_in` before abort (must exceed core latency of ~4480 cycles).
- WORD_W, 32, stream word width; only 32 supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid_in  in  1  ingress word valid
- s_ready_out  out  1  ingress ready (registered)
- s_data_in  in  32  ingress word
- s_last_in  in  1  marks final ingress word of a job
- s_encrypt_in  in  1  job direction, sampled with word 0 (1 = encrypt)
- key_out  out  128  to core key
- iv_out  out  128  to core IV
- associated_data_out  out  128  to core AD
- plaintext_out  out  128  payload when encrypting, else 0
- ciphertext_out  out  128  payload when decrypting, else 0
- data_length_out  out  64  to core length
- start_out  out  1  core start level
- encrypt_out  out  1  core direction
- core_ready_in  in  1  core done
- core_ciphertext_in  in  128  core ciphertext result
- core_plaintext_in  in  128  core plaintext result
- core_tag_in  in  128  core tag
- m_valid_out  out  1  egress valid
- m_ready_in  in  1  egress ready
- m_data_out  out  32  egress word
- m_last_out  out  1  final egress word
- busy_out  out  1  state != IDLE
- frame_err_out  out  1  sticky framing error
- timeout_out  out  1  sticky timeout error

Behaviour:
- Reset (`rst` low, async):
  - All outputs 0 and state IDLE; word counter and timeout counter 0.
  - `s_ready_out` rises on the first clock edge after `rst` goes high.
- States: IDLE, LOAD, RUN, DRAIN.
- Ingress transfer occurs on `s_valid_in && s_ready_out`. A job is exactly 18 words, each field MSW first:
  - words 0-3: key[127:0]
  - words 4-7: IV
  - words 8-11: AD
  - words 12-15: payload
  - words 16-17: length[63:0]
- IDLE:
  - Word 0 accepted -> LOAD.
  - `encrypt_out` <= `s_encrypt_in`.
  - `frame_err_out` and `timeout_out` cleared.
- LOAD: the word counter increments per accepted word.
- Framing:
  - `s_last_in` must be 1 on word 17 and 0 on all other words.
  - Any mismatch -> `frame_err_out` = 1, job discarded, state -> IDLE. No `start_out` is issued.
- Word 17 accepted with `s_last_in` = 1:
  - `s_ready_out` deasserts on that same edge.
  - State -> RUN; `start_out` = 1 from the next cycle.
- RUN:
  - All core input buses are held stable.
  - Timeout counter increments every cycle.
  - `core_ready_in` = 1 -> capture into a 256-bit shift register: result (`core_ciphertext_in` if encrypt, else `core_plaintext_in`) in the upper 128 bits, `core_tag_in` in the lower 128 bits. Then `start_out` <= 0 and state -> DRAIN.
  - Counter reaches TIMEOUT_CYC with no ready -> `timeout_out` = 1, `start_out` <= 0, state -> IDLE.
  - Ready arriving on the same cycle the counter reaches TIMEOUT_CYC: ready wins.
- DRAIN:
  - `m_valid_out` = 1; `m_data_out` = shift register [255:224].
  - Shift by 32 on each `m_valid_out && m_ready_in`.
  - 8 words in total: result MSW first, then tag MSW first.
  - `m_last_out` = 1 with word 7 only.
  - Data and last are held while `m_ready_in` = 0.
  - After word 7 is accepted: `m_valid_out` <= 0, state -> IDLE, `s_ready_out` <= 1 on the same edge.
- Latency:
  - Last ingress word accepted -> `start_out` high: 1 cycle.
  - `core_ready_in` high -> `m_valid_out` high: 1 cycle.
- `s_valid_in` is ignored in RUN and DRAIN; `s_ready_out` = 0 there.
- `plaintext_out` / `ciphertext_out` are routed by the latched direction; the unused bus is forced to 0.
- Reset asserted mid-job: immediate return to reset values. No partial egress and no `start_out` glitch after release.

Optional Feature:
ACORN_LOADER_ZEROIZE_EN
- Defined: on every entry to IDLE (after drain, framing error, or timeout), key, IV, AD, payload, length and shift registers are cleared to 0 on that edge.
- Undefined: these registers retain their last values until overwritten by the next job.

Test Plan:
- Encrypt job, 18 words:
  - Stimulus: key = 0x000102..0F, IV = 0x101112..1F, AD = 0, payload = 0xDEADBEEF_00000000_00000000_CAFEF00D, length = 0x00000000_00000080, `s_last_in` on word 17.
  - Required response: `key_out` / `iv_out` / `plaintext_out` / `data_length_out` exact; `ciphertext_out` = 0; `start_out` high 1 cycle after word 17.
- Core model asserts ready 4480 cycles after start, with ciphertext = 0xA5A5..A5 and tag = 0x0123..EF:
  - Required egress: 8 words A5A5A5A5 x4 then 01234567, 89ABCDEF, 01234567, 89ABCDEF.
  - `m_last_out` on word 7 only; `start_out` low after capture.
- Egress backpressure: hold `m_ready_in` = 0 for 5 cycles at word 3 -> `m_data_out` is stable and no word is lost or duplicated.
- Framing: `s_last_in` = 1 on word 9 -> `frame_err_out` = 1, `start_out` never rises, `s_ready_out` = 1. The next valid job clears the flag.
- Timeout: run with TIMEOUT_CYC = 16 and the core never ready -> `timeout_out` = 1 at cycle 16 of RUN and state returns to IDLE. With the macro defined, `key_out` = 0.
- Reset: assert `rst` low during DRAIN word 2 -> all outputs 0 immediately; a fresh job after release completes normally.
